// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: redirect/stall controls, instruction-memory port and the IF/ID outputs.
// The master side is the fetch stage; the slave side is the surrounding pipeline and memory.
interface fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    modport master (
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  imem_rdata,
        output imem_addr,
        output instr_out,
        output pc_out,
        output instr_valid
    );

    modport slave (
        output stall,
        output branch_taken,
        output branch_target,
        output imem_rdata,
        input  imem_addr,
        input  instr_out,
        input  pc_out,
        input  instr_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID register: PC, synchronous-read imem addressing, stall hold,
// J-type jump and taken-branch redirect with all-zero bubbles on squash.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);
    localparam logic [5:0] OP_J = 6'd2;

    // pc_q is the address whose data is on imem_rdata this cycle.
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_out_q;
    logic        valid_q;

    logic [31:0] pc_out_plus4;
    logic [31:0] jump_target;
    logic        jmp;
    logic [31:0] next_addr;

    assign jmp          = valid_q && (instr_q[31:26] == OP_J);
    assign pc_out_plus4 = pc_out_q + 32'd4;
    assign jump_target  = {pc_out_plus4[31:28], instr_q[25:0], 2'b00};

    always_comb begin
        next_addr = pc_q + 32'd4;
        if (!rst) begin
            next_addr = RESET_PC;
        end else if (bus.branch_taken) begin
            next_addr = bus.branch_target;
        end else if (bus.stall) begin
            // Re-issue so the memory returns the same word when the stall ends.
            next_addr = pc_q;
        end else if (jmp) begin
            next_addr = jump_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            pc_out_q <= 32'h0;
            valid_q  <= 1'b0;
        end else begin
            pc_q <= next_addr;
            if (bus.branch_taken) begin
                instr_q <= 32'h0;
                valid_q <= 1'b0;
            end else if (!bus.stall) begin
                if (jmp) begin
                    // Squash the sequential word fetched behind the jump.
                    instr_q <= 32'h0;
                    valid_q <= 1'b0;
                end else begin
                    instr_q  <= bus.imem_rdata;
                    pc_out_q <= pc_q;
                    valid_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.imem_addr   = next_addr;
    assign bus.instr_out   = instr_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.instr_valid = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of expected (pc, instr) pairs popped by a monitor,
// plus direct checks of imem_addr and bubble state around stalls, jumps, branches and reset.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];
    logic        stall_at_edge;
    logic        rst_at_edge;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0020: return 32'h0800_0010;
            32'h0000_0108: return 32'h0800_00C0;
            default:       return a + 32'h100;
        endcase
    endfunction

    // Synchronous-read memory model and record of what the DUT saw at each edge.
    always @(posedge clk) begin
        bus.imem_rdata <= mem_word(bus.imem_addr);
        stall_at_edge  <= bus.stall;
        rst_at_edge    <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input logic [31:0] pc, input logic [31:0] instr);
        exp_pc_q.push_back(pc);
        exp_instr_q.push_back(instr);
    endtask

    // A new instruction is presented after any non-reset, non-stalled edge that left valid high.
    always @(negedge clk) begin
        if (rst_at_edge === 1'b1 && stall_at_edge === 1'b0 && bus.instr_valid === 1'b1) begin
            if (exp_pc_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got pc %h instr %h expected none",
                         bus.pc_out, bus.instr_out);
            end else begin
                check("sb_pc", bus.pc_out, exp_pc_q.pop_front());
                check("sb_instr", bus.instr_out, exp_instr_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string name, input logic [31:0] pc);
        check({name, "_valid"}, {31'b0, bus.instr_valid}, 32'h0);
        check({name, "_instr"}, bus.instr_out, 32'h0);
        check({name, "_pc"}, bus.pc_out, pc);
    endtask

    initial begin
        rst               = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        #1;
        check("reset_addr0", bus.imem_addr, 32'h0);
        step();
        check_bubble("reset_state", 32'h0);
        check("reset_addr1", bus.imem_addr, 32'h0);
        step();
        step();
        check("reset_addr3", bus.imem_addr, 32'h0);

        rst = 1'b1;
        #1;
        check("release_addr", bus.imem_addr, 32'h4);
        expect_instr(32'h00, 32'h100);
        expect_instr(32'h04, 32'h104);
        expect_instr(32'h08, 32'h108);
        step();
        check("first_instr", bus.instr_out, 32'h100);
        check("first_pc", bus.pc_out, 32'h0);
        check("first_valid", {31'b0, bus.instr_valid}, 32'h1);
        check("seq_addr8", bus.imem_addr, 32'h8);
        step();
        check("seq_addrc", bus.imem_addr, 32'hC);
        step();

        // Stall two cycles while instr_out holds the word from address 8.
        bus.stall = 1'b1;
        #1;
        check("stall_addr", bus.imem_addr, 32'hC);
        expect_instr(32'h0C, 32'h10C);
        expect_instr(32'h10, 32'h110);
        expect_instr(32'h14, 32'h114);
        expect_instr(32'h18, 32'h118);
        expect_instr(32'h1C, 32'h11C);
        expect_instr(32'h20, 32'h0800_0010);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_hold_instr", bus.instr_out, 32'h108);
            check("stall_hold_pc", bus.pc_out, 32'h8);
            check("stall_reissue", bus.imem_addr, 32'hC);
        end
        bus.stall = 1'b0;
        #1;
        check("unstall_addr", bus.imem_addr, 32'h10);

        // Jump word at 0x20 redirects to 0x40 with one bubble.
        for (int i = 0; i < 6; i++) step();
        check("jump_addr", bus.imem_addr, 32'h40);
        expect_instr(32'h40, 32'h140);
        expect_instr(32'h44, 32'h144);
        step();
        check_bubble("jump_bubble", 32'h20);
        check("post_jump_addr", bus.imem_addr, 32'h44);
        step();
        check("jump_target_pc", bus.pc_out, 32'h40);
        step();

        // Branch with simultaneous stall: branch wins.
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h100;
        bus.stall         = 1'b1;
        #1;
        check("branch_stall_addr", bus.imem_addr, 32'h100);
        expect_instr(32'h100, 32'h200);
        expect_instr(32'h104, 32'h204);
        expect_instr(32'h108, 32'h0800_00C0);
        step();
        check_bubble("branch_bubble", 32'h44);
        bus.branch_taken = 1'b0;
        bus.stall        = 1'b0;
        #1;
        check("post_branch_addr", bus.imem_addr, 32'h104);

        // Branch while a jump (target 0x300) sits in IF/ID: branch target wins.
        step();
        step();
        step();
        check("jump_in_ifid", bus.instr_out, 32'h0800_00C0);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h200;
        #1;
        check("branch_over_jump_addr", bus.imem_addr, 32'h200);
        expect_instr(32'h200, 32'h300);
        expect_instr(32'h204, 32'h304);
        step();
        check_bubble("branch_jump_bubble", 32'h108);
        bus.branch_taken = 1'b0;
        #1;
        check("post_branch_jump_addr", bus.imem_addr, 32'h204);
        step();
        step();

        // Reset during a stall.
        bus.stall = 1'b1;
        rst       = 1'b0;
        #1;
        check("reset_stall_addr", bus.imem_addr, 32'h0);
        expect_instr(32'h00, 32'h100);
        expect_instr(32'h04, 32'h104);
        step();
        check_bubble("reset_stall_state", 32'h0);
        rst       = 1'b1;
        bus.stall = 1'b0;
        #1;
        check("restart_addr", bus.imem_addr, 32'h4);
        step();
        step();
        #6;
        check("sb_drained", exp_pc_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
